bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//   Round-robin arbiter for the shared bus. Up to 8 masters request ownership.
//   One master is granted at a time.
//   Produces the registered 3-bit owner index consumed by the 3-to-8 select decoder.
//   Also produces a valid flag that gates the decoded selects.
//   Fairness: after each release, the search pointer advances past the last owner.
// PARAMETERS
//   IDX_W     3    width of grant index; number of masters N = 1<<IDX_W (8)
//   MAX_HOLD  16   max consecutive BUSY cycles per grant (used only with BUS_ARB_TIMEOUT_EN)
//   CNT_W     5    hold-counter width; must hold MAX_HOLD
// PORTS
//   clk          in   1      single bus clock; all logic on rising edge
//   rst          in   1      synchronous, active-high reset
//   req          in   N      per-master request; level, held for whole transfer
//   grant_idx    out  IDX_W  index of current owner (feeds decoder input)
//   grant_valid  out  1      grant_idx is a live grant; decoder output ignored when 0
//   timeout      out  1      1-cycle pulse: grant revoked by hold limit
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, ptr=0, grant_idx=0, grant_valid=0, timeout=0, cnt=0.
//   Reset wins over every other event; a mid-transfer grant drops at that same edge.
//   All outputs are registered; no combinational path from req to any output.
//   States:
//   - IDLE: if |req, pick = first i with req[i] set, searching ptr, ptr+1, ... mod N.
//     Then grant_idx<=pick, grant_valid<=1, cnt<=1, go BUSY.
//     Else remain IDLE, grant_valid=0.
//   - BUSY: hold grant_idx while req[grant_idx]=1; cnt increments, saturating.
//   - BUSY, req[grant_idx]=0 (release):
//     grant_valid<=0, ptr<=grant_idx+1 (wraps 7->0), go IDLE.
//   Latency:
//   - req rise in IDLE -> grant_valid=1 at the next edge (1 cycle).
//   - Release -> grant_valid=0 at the next edge.
//   - Minimum one IDLE turnaround cycle between grants (bus handover gap).
//   Requests from other masters during BUSY are ignored until IDLE (no preemption).
//   grant_idx keeps its last value while grant_valid=0.
//   A request dropped before it is granted is simply never served; no memory of it.
//   Release and timeout in the same cycle are handled as a release: no timeout pulse.
// CONFIGURATION
//   BUS_ARB_TIMEOUT_EN defined:
//   - In BUSY, when cnt==MAX_HOLD and req[grant_idx] is still 1:
//     grant_valid<=0, timeout<=1 for one cycle, ptr<=grant_idx+1, go IDLE.
//   - The offender is re-eligible but is now lowest priority.
//   BUS_ARB_TIMEOUT_EN undefined:
//   - No counter logic; timeout tied 0; a grant is held indefinitely.
// STRUCTURE
//   Shared package bus_defs holds:
//   - IDX_W, N;
//   - state encoding localparams ST_IDLE=1'b0, ST_BUSY=1'b1.
//   The decoder stage uses the same IDX_W from bus_defs.
//   One sub-module: rr_pick.
//   - Combinational rotate-by-ptr, priority-encode, rotate-back.
//   - Inputs req, ptr; outputs pick[IDX_W-1:0], any.
//   Top module: FSM, ptr register, output registers, optional hold counter.
// TESTING
//   1. rst=1 two cycles, req=8'h00 -> grant_valid=0, grant_idx=0, timeout=0.
//   2. ptr=0, req=8'b0010_0100 -> next edge idx=2, valid=1.
//      Drop req[2] -> valid=0 next edge. Next grant idx=5 (ptr=3).
//   3. Wrap: grant idx=6, then release; req=8'b1000_0001 -> idx=7.
//      Release -> idx=0.
//   4. req=8'hFF, each owner releases after 2 BUSY cycles (re-raises later).
//      -> grant order 0,1,2,...,7,0; every grant separated by one IDLE cycle.
//   5. BUS_ARB_TIMEOUT_EN, MAX_HOLD=16, req[4] held, req[1] pending.
//      -> valid drops after 16 BUSY cycles; timeout=1 for exactly one cycle.
//      -> Next grant idx=1.
//   6. rst=1 while BUSY on idx=3 -> next edge valid=0, idx=0, ptr=0.
//      After rst release, req=8'h08 -> idx=3.

Source files
------------

// File: rtl/bus_defs.sv
// Shared bus definitions: grant index width, master count and arbiter state encoding.
package bus_defs;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned N     = 1 << IDX_W;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [N-1:0]     req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Successor of an owner index, wrapping N-1 -> 0.
  function automatic idx_t idx_next(input idx_t i);
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: rotate requests by ptr, take the lowest set bit, rotate the index back.
module rr_pick
  import bus_defs::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    // Descending scan so the lowest set bit of the rotated vector wins.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    pick = off + ptr;
    any  = |req;
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with registered owner index and valid flag.
// Optional hold-limit revocation enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter
  import bus_defs::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  if (CNT_W < $clog2(MAX_HOLD + 1)) begin : g_cnt_w_check
    $error("CNT_W too narrow for MAX_HOLD");
  end

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick;
  logic             any;

  rr_pick u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      cnt         <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            grant_idx   <= pick;
            grant_valid <= 1'b1;
            cnt         <= CNT_W'(1);
            state       <= ST_BUSY;
          end else begin
            grant_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          // Release takes precedence over the hold limit.
          if (!req[grant_idx]) begin
            grant_valid <= 1'b0;
            ptr         <= idx_next(grant_idx);
            state       <= ST_IDLE;
          end else if (cnt == CNT_W'(MAX_HOLD)) begin
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
            ptr         <= idx_next(grant_idx);
            state       <= ST_IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  assign timeout = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            grant_idx   <= pick;
            grant_valid <= 1'b1;
            state       <= ST_BUSY;
          end else begin
            grant_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (!req[grant_idx]) begin
            grant_valid <= 1'b0;
            ptr         <= idx_next(grant_idx);
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus random request traffic against a cycle model.
module tb_bus_rr_arbiter;

  localparam int MAXH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  // Reference: owner/ptr bookkeeping straight from the arbitration rules.
  bit m_valid = 0;
  bit m_to    = 0;
  int m_idx   = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      m_to = 0;
      if (!m_valid) begin
        if (req != 8'h00) begin
          for (int k = 0; k < 8; k++) begin
            if (!m_valid && req[(m_ptr + k) % 8]) begin
              m_idx = (m_ptr + k) % 8;
              m_valid = 1;
              m_cnt = 1;
            end
          end
        end
      end else if (!req[m_idx]) begin
        m_valid = 0;
        m_ptr = (m_idx + 1) % 8;
      end else begin
`ifdef BUS_ARB_TIMEOUT_EN
        if (m_cnt == MAXH) begin
          m_valid = 0;
          m_to = 1;
          m_ptr = (m_idx + 1) % 8;
        end else begin
          m_cnt = m_cnt + 1;
        end
`else
        m_cnt = m_cnt + 1;
`endif
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare all outputs with the model.
  task automatic tick();
    @(negedge clk);
    cmp("model_valid",   32'(grant_valid), 32'(m_valid));
    cmp("model_idx",     32'(grant_idx),   32'(m_idx));
    cmp("model_timeout", 32'(timeout),     32'(m_to));
  endtask

  initial begin
    int n;
    // Reset
    rst = 1'b1; req = 8'h00;
    tick(); tick();
    cmp("rst_valid", 32'(grant_valid), 0);
    cmp("rst_idx", 32'(grant_idx), 0);
    cmp("rst_timeout", 32'(timeout), 0);
    rst = 1'b0;

    // Basic grant, release, pointer advance
    req = 8'b0010_0100;
    tick();
    cmp("t2_idx", 32'(grant_idx), 2);
    cmp("t2_valid", 32'(grant_valid), 1);
    req = 8'b0010_0000;
    tick();
    cmp("t2_rel_valid", 32'(grant_valid), 0);
    tick();
    cmp("t2_next_idx", 32'(grant_idx), 5);
    cmp("t2_next_valid", 32'(grant_valid), 1);

    // Wrap-around
    req = 8'h40;
    tick();
    tick();
    cmp("t3_idx6", 32'(grant_idx), 6);
    req = 8'h00;
    tick();
    req = 8'h81;
    tick();
    cmp("t3_idx7", 32'(grant_idx), 7);
    req = 8'h01;
    tick();
    cmp("t3_rel_valid", 32'(grant_valid), 0);
    tick();
    cmp("t3_idx0", 32'(grant_idx), 0);
    cmp("t3_valid0", 32'(grant_valid), 1);
    req = 8'h00;
    tick(); tick();

    // All request: strict rotation with one idle gap per handover
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'hFF;
    tick();
    for (int g = 0; g < 9; g++) begin
      cmp("t4_order", 32'(grant_idx), 32'(g % 8));
      cmp("t4_valid", 32'(grant_valid), 1);
      tick();
      req[g % 8] = 1'b0;
      tick();
      cmp("t4_gap", 32'(grant_valid), 0);
      req[g % 8] = 1'b1;
      tick();
    end
    req = 8'h00;
    tick(); tick();

    // Hold limit
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'h10;
    tick();
    cmp("t5_idx4", 32'(grant_idx), 4);
    req = 8'h12;
`ifdef BUS_ARB_TIMEOUT_EN
    n = 1;
    for (int k = 0; k < 40 && grant_valid; k++) begin
      tick();
      if (grant_valid) n++;
    end
    cmp("t5_busy_cycles", 32'(n), 16);
    cmp("t5_timeout_pulse", 32'(timeout), 1);
    tick();
    cmp("t5_timeout_clear", 32'(timeout), 0);
    cmp("t5_next_idx", 32'(grant_idx), 1);
    cmp("t5_next_valid", 32'(grant_valid), 1);
`else
    n = 0;
    repeat (20) tick();
    cmp("t5_hold_valid", 32'(grant_valid), 1);
    cmp("t5_hold_idx", 32'(grant_idx), 4);
    cmp("t5_no_timeout", 32'(timeout), 0);
`endif
    req = 8'h00;
    tick(); tick();

    // Reset mid-transfer
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'h08;
    tick();
    cmp("t6_idx3", 32'(grant_idx), 3);
    rst = 1'b1;
    tick();
    cmp("t6_rst_valid", 32'(grant_valid), 0);
    cmp("t6_rst_idx", 32'(grant_idx), 0);
    rst = 1'b0;
    tick();
    cmp("t6_regrant_idx", 32'(grant_idx), 3);
    cmp("t6_regrant_valid", 32'(grant_valid), 1);
    req = 8'h00;
    tick();

    // Random level requests with occasional reset
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst = ($urandom_range(0, 499) == 0);
      for (int b = 0; b < 8; b++) begin
        if (req[b]) begin
          if ($urandom_range(0, 9) == 0) req[b] = 1'b0;
        end else begin
          if ($urandom_range(0, 5) == 0) req[b] = 1'b1;
        end
      end
    end
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
